// File: rtl/spike_count_classifier_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spike_count_classifier_if                                    |
// | Description : Control, spike input and result handshake bundle for the     |
// |               spike count classifier readout stage.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface spike_count_classifier_if #(
  parameter int N_OUTPUT    = 3,
  parameter int COUNT_WIDTH = 8,
  parameter int CLASS_WIDTH = 2
);
  logic                   start;
  logic [N_OUTPUT-1:0]    spikes_in;
  logic                   busy;
  logic                   result_valid;
  logic                   result_ready;
  logic [CLASS_WIDTH-1:0] class_id;
  logic [COUNT_WIDTH-1:0] class_count;
  logic                   tie;
  logic                   no_spike;

  // Environment side: requests windows, supplies spikes, consumes results
  modport master (
    output start, spikes_in, result_ready,
    input  busy, result_valid, class_id, class_count, tie, no_spike
  );

  // Classifier side
  modport slave (
    input  start, spikes_in, result_ready,
    output busy, result_valid, class_id, class_count, tie, no_spike
  );
endinterface
`default_nettype wire

// File: rtl/spike_count_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spike_count_classifier                                       |
// | Description : Counts output-layer spikes per neuron over a fixed window,   |
// |               scans the counts one per cycle for the winning class and     |
// |               presents it on a valid/ready handshake.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spike_count_classifier #(
  parameter int N_OUTPUT      = 3,
  parameter int WINDOW_CYCLES = 64,
  parameter int COUNT_WIDTH   = 8,
  parameter int CLASS_WIDTH   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  spike_count_classifier_if.slave cls_if
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_SELECT = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [WIN_W-1:0]       WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CLASS_WIDTH-1:0] IDX_LAST = CLASS_WIDTH'(N_OUTPUT - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [1:0]             state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q [N_OUTPUT];
  logic [COUNT_WIDTH-1:0] cnt_d [N_OUTPUT];
  logic [WIN_W-1:0]       win_q, win_d;
  logic [CLASS_WIDTH-1:0] idx_q, idx_d;
  logic [CLASS_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [COUNT_WIDTH-1:0] best_cnt_q, best_cnt_d;
  logic                   best_tie_q, best_tie_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic [CLASS_WIDTH-1:0] class_id_q, class_id_d;
  logic [COUNT_WIDTH-1:0] class_cnt_q, class_cnt_d;
  logic                   tie_q, tie_d;
  logic                   no_spike_q, no_spike_d;
  logic [COUNT_WIDTH-1:0] scan_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cls_if.start)                     state_d = S_COUNT;
      S_COUNT:  if (win_q == WIN_LAST)                state_d = S_SELECT;
      S_SELECT: if (idx_q == IDX_LAST)                state_d = S_HOLD;
      S_HOLD:   if (valid_q && cls_if.result_ready)   state_d = S_IDLE;
      default:                                        state_d = S_IDLE;
    endcase
  end

  // Count of the neuron currently under the scan index
  always_comb begin
    scan_cnt = '0;
    for (int j = 0; j < N_OUTPUT; j++) begin
      if (idx_q == CLASS_WIDTH'(j)) scan_cnt = cnt_q[j];
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d       = cnt_q;
    win_d       = win_q;
    idx_d       = idx_q;
    best_idx_d  = best_idx_q;
    best_cnt_d  = best_cnt_q;
    best_tie_d  = best_tie_q;
    class_id_d  = class_id_q;
    class_cnt_d = class_cnt_q;
    tie_d       = tie_q;
    no_spike_d  = no_spike_q;
    busy_d      = (state_d != S_IDLE);
    valid_d     = (state_d == S_HOLD);
    case (state_q)
      S_IDLE: begin
        if (cls_if.start) begin
          for (int j = 0; j < N_OUTPUT; j++) cnt_d[j] = '0;
          win_d = '0;
        end
      end
      S_COUNT: begin
        win_d = win_q + 1'b1;
        for (int j = 0; j < N_OUTPUT; j++) begin
          if (cls_if.spikes_in[j] && (cnt_q[j] != CNT_MAX)) cnt_d[j] = cnt_q[j] + 1'b1;
        end
        if (win_q == WIN_LAST) begin
          idx_d      = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          best_tie_d = 1'b0;
        end
      end
      S_SELECT: begin
        idx_d = idx_q + 1'b1;
        // Strictly greater takes over, so the lowest index keeps a tie
        if (scan_cnt > best_cnt_q) begin
          best_idx_d = idx_q;
          best_cnt_d = scan_cnt;
          best_tie_d = 1'b0;
        end else if ((scan_cnt == best_cnt_q) && (idx_q != '0)) begin
          best_tie_d = 1'b1;
        end
        if (idx_q == IDX_LAST) begin
          idx_d       = '0;
          class_id_d  = best_idx_d;
          class_cnt_d = best_cnt_d;
          no_spike_d  = (best_cnt_d == '0);
          tie_d       = best_tie_d || (best_cnt_d == '0);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < N_OUTPUT; j++) cnt_q[j] <= '0;
      win_q       <= '0;
      idx_q       <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      best_tie_q  <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      class_id_q  <= '0;
      class_cnt_q <= '0;
      tie_q       <= 1'b0;
      no_spike_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      idx_q       <= idx_d;
      best_idx_q  <= best_idx_d;
      best_cnt_q  <= best_cnt_d;
      best_tie_q  <= best_tie_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      class_id_q  <= class_id_d;
      class_cnt_q <= class_cnt_d;
      tie_q       <= tie_d;
      no_spike_q  <= no_spike_d;
    end
  end

  assign cls_if.busy         = busy_q;
  assign cls_if.result_valid = valid_q;
  assign cls_if.class_id     = class_id_q;
  assign cls_if.class_count  = class_cnt_q;
  assign cls_if.tie          = tie_q;
  assign cls_if.no_spike     = no_spike_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_count_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spike_count_classifier                                    |
// | Description : Self-checking bench for spike_count_classifier. Three        |
// |               instances cover default, short-window and narrow-counter     |
// |               configurations; one is selected at a time.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spike_count_classifier;

  localparam int N = 3;

  typedef struct packed {
    logic       busy;
    logic       valid;
    logic [1:0] id;
    logic [7:0] cnt;
    logic       tie;
    logic       ns;
  } obs_t;

  typedef struct {
    int         k;
    int         n0, n1, n2;
    logic [1:0] id;
    int         cnt;
    bit         tie;
    bit         ns;
    int         stall;
    bit         noise;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         tb_start;
  logic [N-1:0] tb_spikes;
  logic         tb_ready;
  int           sel;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  spike_count_classifier_if #(.N_OUTPUT(3), .COUNT_WIDTH(8), .CLASS_WIDTH(2)) if0 ();
  spike_count_classifier_if #(.N_OUTPUT(3), .COUNT_WIDTH(8), .CLASS_WIDTH(2)) if1 ();
  spike_count_classifier_if #(.N_OUTPUT(3), .COUNT_WIDTH(4), .CLASS_WIDTH(2)) if2 ();

  assign if0.start        = tb_start && (sel == 0);
  assign if1.start        = tb_start && (sel == 1);
  assign if2.start        = tb_start && (sel == 2);
  assign if0.spikes_in    = tb_spikes;
  assign if1.spikes_in    = tb_spikes;
  assign if2.spikes_in    = tb_spikes;
  assign if0.result_ready = tb_ready;
  assign if1.result_ready = tb_ready;
  assign if2.result_ready = tb_ready;

  spike_count_classifier #(.N_OUTPUT(3), .WINDOW_CYCLES(64), .COUNT_WIDTH(8), .CLASS_WIDTH(2))
    u_dut0 (.clk(clk), .rst(rst), .cls_if(if0));
  spike_count_classifier #(.N_OUTPUT(3), .WINDOW_CYCLES(8), .COUNT_WIDTH(8), .CLASS_WIDTH(2))
    u_dut1 (.clk(clk), .rst(rst), .cls_if(if1));
  spike_count_classifier #(.N_OUTPUT(3), .WINDOW_CYCLES(16), .COUNT_WIDTH(4), .CLASS_WIDTH(2))
    u_dut2 (.clk(clk), .rst(rst), .cls_if(if2));

  function automatic obs_t get_obs(int k);
    obs_t o;
    o = '0;
    case (k)
      0: begin
        o.busy = if0.busy; o.valid = if0.result_valid; o.id = if0.class_id;
        o.cnt = if0.class_count; o.tie = if0.tie; o.ns = if0.no_spike;
      end
      1: begin
        o.busy = if1.busy; o.valid = if1.result_valid; o.id = if1.class_id;
        o.cnt = if1.class_count; o.tie = if1.tie; o.ns = if1.no_spike;
      end
      default: begin
        o.busy = if2.busy; o.valid = if2.result_valid; o.id = if2.class_id;
        o.cnt = {4'b0, if2.class_count}; o.tie = if2.tie; o.ns = if2.no_spike;
      end
    endcase
    return o;
  endfunction

  function automatic int win_len(int k);
    return (k == 0) ? 64 : ((k == 1) ? 8 : 16);
  endfunction

  // Reference: total spikes per neuron, clipped to the counter ceiling, then argmax
  function automatic obs_t model(int k, logic [2:0] pat[$]);
    obs_t o;
    int   tot [N];
    int   cap, best, bi, nmax;
    cap = (k == 2) ? 15 : 255;
    for (int j = 0; j < N; j++) tot[j] = 0;
    foreach (pat[s]) for (int j = 0; j < N; j++) if (pat[s][j]) tot[j]++;
    best = 0;
    for (int j = 0; j < N; j++) begin
      if (tot[j] > cap) tot[j] = cap;
      if (tot[j] > best) best = tot[j];
    end
    bi = -1; nmax = 0;
    for (int j = 0; j < N; j++) if (tot[j] == best) begin
      nmax++;
      if (bi < 0) bi = j;
    end
    o.busy = 1'b1; o.valid = 1'b1; o.id = 2'(bi); o.cnt = 8'(best);
    o.tie = (nmax > 1); o.ns = (best == 0);
    return o;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full window: start at E0 (with spikes high, which must not count),
  // W samples, N select edges, optional stall, then handshake back to IDLE.
  task automatic run_window(string name, int k, logic [2:0] pat[$], obs_t exp_o,
                            int stall, bit noise);
    obs_t got;
    int   w;
    w = pat.size();
    sel = k; tb_ready = 1'b0;
    tb_start = 1'b1; tb_spikes = '1;
    tick();
    got = get_obs(k);
    chk({name, " busy_after_start"}, 32'(got.busy), 32'd1);
    tb_start = 1'b0;
    for (int s = 0; s < w; s++) begin
      tb_spikes = pat[s];
      tb_start  = (noise && (s == w / 2));
      tick();
    end
    tb_start = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (s == N - 1) begin
        got = get_obs(k);
        chk({name, " valid_not_early"}, 32'(got.valid), 32'd0);
      end
      tb_spikes = 3'($urandom);
      tick();
    end
    tb_spikes = '0;
    got = get_obs(k);
    chk({name, " result"}, 32'(got), 32'(exp_o));
    for (int s = 0; s < stall; s++) begin
      tb_start = noise;
      tick();
      got = get_obs(k);
      chk({name, " stall_stable"}, 32'(got), 32'(exp_o));
    end
    tb_ready = 1'b1; tb_start = noise;
    tick();
    tb_ready = 1'b0; tb_start = 1'b0;
    got = get_obs(k);
    chk({name, " handshake_busy_valid"}, {30'd0, got.busy, got.valid}, 32'd0);
    tick();
    got = get_obs(k);
    chk({name, " stays_idle"}, 32'(got.busy), 32'd0);
  endtask

  task automatic build_pat(int w, int n0, int n1, int n2, output logic [2:0] pat[$]);
    pat.delete();
    for (int s = 0; s < w; s++) pat.push_back({(s < n2), (s < n1), (s < n0)});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl [9];
    logic [2:0] pat[$];
    obs_t       e, got;
    int         d0, d1, d2, w;

    tbl[0] = '{0, 16, 32,  0, 2'd1, 32, 0, 0,  0, 0};
    tbl[1] = '{0, 10, 10,  5, 2'd0, 10, 1, 0,  2, 0};
    tbl[2] = '{0,  0,  0, 64, 2'd2, 64, 0, 0,  1, 1};
    tbl[3] = '{1,  3,  1,  3, 2'd0,  3, 1, 0,  0, 0};
    tbl[4] = '{1,  0,  0,  0, 2'd0,  0, 1, 1,  0, 0};
    tbl[5] = '{1,  8,  8,  8, 2'd0,  8, 1, 0,  3, 1};
    tbl[6] = '{2,  0,  0, 16, 2'd2, 15, 0, 0, 10, 1};
    tbl[7] = '{2, 15, 16,  3, 2'd0, 15, 1, 0,  0, 0};
    tbl[8] = '{2,  0,  1,  0, 2'd1,  1, 0, 0,  0, 0};

    // Reset with spikes held high, then a long idle period
    rst = 1'b0; tb_start = 1'b0; tb_spikes = '1; tb_ready = 1'b0; sel = 0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      got = get_obs(k);
      chk("reset_outputs", 32'(got), 32'd0);
    end
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        got = get_obs(k);
        chk("idle_outputs", 32'(got), 32'd0);
      end
    end

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      build_pat(win_len(tbl[i].k), tbl[i].n0, tbl[i].n1, tbl[i].n2, pat);
      e = '{1'b1, 1'b1, tbl[i].id, 8'(tbl[i].cnt), tbl[i].tie, tbl[i].ns};
      run_window($sformatf("vec%0d", i), tbl[i].k, pat, e, tbl[i].stall, tbl[i].noise);
    end

    // Reset at sample 30 of a 64-sample window (previous result is non-zero)
    sel = 0; tb_start = 1'b1; tb_spikes = '0;
    tick();
    tb_start = 1'b0; tb_spikes = '1;
    for (int s = 1; s < 30; s++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; tb_spikes = '0;
    got = get_obs(0);
    chk("reset_mid_count", 32'(got), 32'd0);
    build_pat(64, 5, 0, 0, pat);
    run_window("after_reset_count", 0, pat, '{1'b1, 1'b1, 2'd0, 8'd5, 1'b0, 1'b0}, 0, 0);

    // Reset on the second select edge of an 8-sample window
    sel = 1; tb_start = 1'b1; tb_spikes = '0;
    tick();
    tb_start = 1'b0; tb_spikes = 3'b011;
    for (int s = 0; s < 8; s++) tick();
    tb_spikes = '0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    got = get_obs(1);
    chk("reset_mid_select", 32'(got), 32'd0);
    build_pat(8, 5, 0, 0, pat);
    run_window("after_reset_select", 1, pat, '{1'b1, 1'b1, 2'd0, 8'd5, 1'b0, 1'b0}, 0, 0);

    // Randomized windows against the reference model
    for (int r = 0; r < 30; r++) begin
      int k;
      k  = $urandom_range(0, 2);
      w  = win_len(k);
      d0 = $urandom_range(0, 100);
      d1 = $urandom_range(0, 100);
      d2 = $urandom_range(0, 100);
      pat.delete();
      for (int s = 0; s < w; s++)
        pat.push_back({($urandom_range(0, 99) < d2), ($urandom_range(0, 99) < d1),
                       ($urandom_range(0, 99) < d0)});
      e = model(k, pat);
      run_window($sformatf("rand%0d", r), k, pat, e, $urandom_range(0, 4), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
